// File: rtl/fifo_sync_pkg.sv
// Shared types and defaults for the parametrised synchronous FIFO.
package fifo_sync_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 32;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic full_n;
      logic empty_n;
      logic afull;
      logic aempty;
   } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port DEPTH x WIDTH RAM, synchronous write and read-first synchronous read.
module fifo_sync_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             CLOCK,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // A read of the address being written returns the old word.
   always_ff @(posedge CLOCK) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param
   import fifo_sync_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic                   CLEAR_N,
   input  logic                   ERR_CLR,
   input  logic                   WRITE,
   input  logic [WIDTH-1:0]       DATA_IN,
   input  logic                   READ,
   output logic [WIDTH-1:0]       DATA_OUT,
   output logic                   F_FULL_N,
   output logic                   F_EMPTY_N,
   output logic                   F_AFULL,
   output logic                   F_AEMPTY,
   output logic [$clog2(DEPTH):0] USE_DW,
   output logic                   OVERFLOW,
   output logic                   UNDERFLOW
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [PW-1:0]    wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
   logic [CW-1:0]    count, count_next;
   fifo_flags_t      flags, flags_next;
   logic             overflow_q, underflow_q, overflow_next, underflow_next;
   logic             flush, wr_acc, rd_acc, zero_out;
   logic             ram_rd_en;
   logic [PW-1:0]    ram_rd_addr;
   logic [WIDTH-1:0] ram_q;

   // Accept decisions use the registered flags; the flags themselves are computed from the next count.
   always_comb begin
      flush       = RESET | ~CLEAR_N;
      wr_acc      = WRITE & (flags.full_n | READ) & ~flush;
      rd_acc      = READ & flags.empty_n & ~flush;
      wr_ptr_next = wr_acc ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_next = rd_acc ? rd_ptr + PW'(1) : rd_ptr;
      count_next  = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
      flags_next.full_n  = (count_next != FULL_CNT);
      flags_next.empty_n = (count_next != '0);
      flags_next.afull   = (count_next >= AF_CNT);
      flags_next.aempty  = (count_next <= AE_CNT);
      overflow_next  = (WRITE & ~flags.full_n & ~READ) | (overflow_q & ~ERR_CLR);
      underflow_next = (READ & ~flags.empty_n) | (underflow_q & ~ERR_CLR);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         flags       <= '{full_n: 1'b1, empty_n: 1'b0, afull: 1'b0, aempty: 1'b1};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         flags  <= flags_next;
         if (CLEAR_N) begin
            overflow_q  <= overflow_next;
            underflow_q <= underflow_next;
         end
      end
   end

`ifdef FIFO_SYNC_FWFT_EN
   logic             bypass_sel;
   logic [WIDTH-1:0] bypass_data;

   // The RAM always fetches the next head; a word written straight into the head slot is forwarded.
   assign ram_rd_en   = 1'b1;
   assign ram_rd_addr = rd_ptr_next;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         zero_out    <= 1'b1;
         bypass_sel  <= 1'b0;
         bypass_data <= '0;
      end else begin
         zero_out    <= ~flags_next.empty_n;
         bypass_sel  <= wr_acc & (wr_ptr == rd_ptr_next);
         bypass_data <= DATA_IN;
      end
   end

   always_comb begin
      DATA_OUT = ram_q;
      if (zero_out)
         DATA_OUT = '0;
      else if (bypass_sel)
         DATA_OUT = bypass_data;
   end
`else
   assign ram_rd_en   = rd_acc;
   assign ram_rd_addr = rd_ptr;

   // The RAM output register is not reset, so a flush masks it until the next accepted read.
   always_ff @(posedge CLOCK) begin
      if (RESET)
         zero_out <= 1'b1;
      else if (flush)
         zero_out <= 1'b1;
      else if (rd_acc)
         zero_out <= 1'b0;
   end

   always_comb begin
      DATA_OUT = zero_out ? '0 : ram_q;
   end
`endif

   fifo_sync_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .CLOCK   (CLOCK),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (DATA_IN),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_q)
   );

   assign F_FULL_N  = flags.full_n;
   assign F_EMPTY_N = flags.empty_n;
   assign F_AFULL   = flags.afull;
   assign F_AEMPTY  = flags.aempty;
   assign USE_DW    = count;
   assign OVERFLOW  = overflow_q;
   assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed test plan plus randomized traffic against a queue model.
module tb_fifo_sync_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int AF    = 28;
   localparam int AE    = 4;

   logic             CLOCK = 1'b0;
   logic             RESET, CLEAR_N, ERR_CLR, WRITE, READ;
   logic [WIDTH-1:0] DATA_IN, DATA_OUT;
   logic             F_FULL_N, F_EMPTY_N, F_AFULL, F_AEMPTY, OVERFLOW, UNDERFLOW;
   logic [5:0]       USE_DW;

   int num_vectors    = 0;
   int num_miscompares = 0;

   logic [7:0] mq [$];
   logic [7:0] m_dout = 8'h00;
   logic       m_ovf  = 1'b0;
   logic       m_unf  = 1'b0;

   always #5 CLOCK = ~CLOCK;

   fifo_sync_param #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .CLEAR_N   (CLEAR_N),
      .ERR_CLR   (ERR_CLR),
      .WRITE     (WRITE),
      .DATA_IN   (DATA_IN),
      .READ      (READ),
      .DATA_OUT  (DATA_OUT),
      .F_FULL_N  (F_FULL_N),
      .F_EMPTY_N (F_EMPTY_N),
      .F_AFULL   (F_AFULL),
      .F_AEMPTY  (F_AEMPTY),
      .USE_DW    (USE_DW),
      .OVERFLOW  (OVERFLOW),
      .UNDERFLOW (UNDERFLOW)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_vectors++;
      if (observed !== expected) begin
         num_miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour: a bounded queue with the accept/error rules applied to the pre-edge state.
   task automatic modelStep(input logic rst, input logic clr_n, input logic eclr,
                            input logic wr, input logic [7:0] din, input logic rd);
      bit full, empty, wacc, racc, oev, uev;
      logic [7:0] popped;
      if (rst) begin
         mq.delete();
         m_dout = 8'h00;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else if (!clr_n) begin
         mq.delete();
         m_dout = 8'h00;
      end else begin
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         wacc  = wr && (!full || rd);
         racc  = rd && !empty;
         oev   = wr && !wacc;
         uev   = rd && empty;
         if (racc) begin
            popped = mq.pop_front();
`ifndef FIFO_SYNC_FWFT_EN
            m_dout = popped;
`endif
         end
         if (wacc)
            mq.push_back(din);
         m_ovf = oev || (m_ovf && !eclr);
         m_unf = uev || (m_unf && !eclr);
      end
`ifdef FIFO_SYNC_FWFT_EN
      m_dout = (mq.size() != 0) ? mq[0] : 8'h00;
`endif
   endtask

   task automatic checkAll();
      int n;
      n = mq.size();
      checkOutput("data_out",  {24'h0, DATA_OUT},  {24'h0, m_dout});
      checkOutput("use_dw",    {26'h0, USE_DW},    n);
      checkOutput("full_n",    {31'h0, F_FULL_N},  {31'h0, (n != DEPTH)});
      checkOutput("empty_n",   {31'h0, F_EMPTY_N}, {31'h0, (n != 0)});
      checkOutput("afull",     {31'h0, F_AFULL},   {31'h0, (n >= AF)});
      checkOutput("aempty",    {31'h0, F_AEMPTY},  {31'h0, (n <= AE)});
      checkOutput("overflow",  {31'h0, OVERFLOW},  {31'h0, m_ovf});
      checkOutput("underflow", {31'h0, UNDERFLOW}, {31'h0, m_unf});
   endtask

   task automatic applyStimulus(input logic rst, input logic clr_n, input logic eclr,
                                input logic wr, input logic [7:0] din, input logic rd);
      RESET   = rst;
      CLEAR_N = clr_n;
      ERR_CLR = eclr;
      WRITE   = wr;
      DATA_IN = din;
      READ    = rd;
      @(posedge CLOCK);
      modelStep(rst, clr_n, eclr, wr, din, rd);
      #1;
      checkAll();
   endtask

   initial begin
      RESET = 1'b1; CLEAR_N = 1'b1; ERR_CLR = 1'b0;
      WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00;

      applyStimulus(1, 1, 0, 0, 8'h00, 0);
      applyStimulus(1, 1, 0, 0, 8'h00, 0);
      checkOutput("rst_use_dw", {26'h0, USE_DW}, 0);
      checkOutput("rst_empty_n", {31'h0, F_EMPTY_N}, 0);
      checkOutput("rst_aempty", {31'h0, F_AEMPTY}, 1);

      // Fill with 0x01..0x20
      for (int i = 1; i <= 32; i++) begin
         applyStimulus(0, 1, 0, 1, 8'(i), 0);
         checkOutput("fill_afull", {31'h0, F_AFULL}, {31'h0, (i >= 28)});
         checkOutput("fill_aempty", {31'h0, F_AEMPTY}, {31'h0, (i <= 4)});
      end
      checkOutput("fill_use_dw", {26'h0, USE_DW}, 32);
      checkOutput("fill_full_n", {31'h0, F_FULL_N}, 0);

      applyStimulus(0, 1, 0, 1, 8'h55, 0);
      applyStimulus(0, 1, 0, 1, 8'h55, 0);
      checkOutput("ovf_use_dw", {26'h0, USE_DW}, 32);
      checkOutput("ovf_flag", {31'h0, OVERFLOW}, 1);

      applyStimulus(0, 1, 0, 1, 8'hAA, 1);
`ifndef FIFO_SYNC_FWFT_EN
      checkOutput("fullrw_data", {24'h0, DATA_OUT}, 32'h01);
`endif
      checkOutput("fullrw_use_dw", {26'h0, USE_DW}, 32);
      applyStimulus(0, 1, 1, 0, 8'h00, 0);
      checkOutput("errclr_ovf", {31'h0, OVERFLOW}, 0);

      // Drain through the wrap point
      for (int i = 0; i < 32; i++)
         applyStimulus(0, 1, 0, 0, 8'h00, 1);
      checkOutput("drain_use_dw", {26'h0, USE_DW}, 0);
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      checkOutput("unf_flag", {31'h0, UNDERFLOW}, 1);
`ifndef FIFO_SYNC_FWFT_EN
      checkOutput("unf_hold", {24'h0, DATA_OUT}, 32'hAA);
`endif

      applyStimulus(0, 1, 0, 1, 8'hBB, 1);
      checkOutput("emptyrw_use_dw", {26'h0, USE_DW}, 1);
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
`ifndef FIFO_SYNC_FWFT_EN
      checkOutput("emptyrw_next", {24'h0, DATA_OUT}, 32'hBB);
`endif

      for (int i = 0; i < 16; i++)
         applyStimulus(0, 1, 0, 1, 8'(8'h81 + i), 0);
      applyStimulus(0, 0, 0, 1, 8'h00, 1);
      checkOutput("clr_use_dw", {26'h0, USE_DW}, 0);
      checkOutput("clr_data", {24'h0, DATA_OUT}, 0);
      checkOutput("clr_unf_kept", {31'h0, UNDERFLOW}, 1);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 0, 1, 8'(8'hC0 + i), 0);
      checkOutput("postclr_use_dw", {26'h0, USE_DW}, 4);
      applyStimulus(1, 1, 0, 1, 8'h77, 0);
      checkOutput("rst_unf", {31'h0, UNDERFLOW}, 0);
      checkOutput("rst_use_dw2", {26'h0, USE_DW}, 0);

`ifdef FIFO_SYNC_FWFT_EN
      applyStimulus(0, 1, 0, 1, 8'h11, 0);
      checkOutput("fwft_data", {24'h0, DATA_OUT}, 32'h11);
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      checkOutput("fwft_empty_n", {31'h0, F_EMPTY_N}, 0);
`endif

      // Randomized traffic in write-heavy, read-heavy and balanced phases
      for (int i = 0; i < 3000; i++) begin
         int phase, pw, pr;
         logic rst, clr_n, eclr, wr, rd;
         phase = (i / 200) % 3;
         pw = (phase == 0) ? 85 : (phase == 1) ? 20 : 50;
         pr = (phase == 0) ? 20 : (phase == 1) ? 85 : 50;
         rst   = ($urandom_range(499) == 0);
         clr_n = ($urandom_range(299) != 0);
         eclr  = ($urandom_range(39) == 0);
         wr    = ($urandom_range(99) < pw);
         rd    = ($urandom_range(99) < pr);
         applyStimulus(rst, clr_n, eclr, wr, 8'($urandom), rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule
